// File: rtl/sid_multi_regfile.sv
// sid_multi_regfile
// Register file and bus interface for N_SID SID chips sharing one 6502-style
// bus. Captures the write-only registers 0x00..0x18 of each chip, returns the
// read-only registers 0x19..0x1C (POTX, POTY, OSC3, ENV3) and emulates the
// per-chip data-bus value retention: reads of write-only or unmapped
// addresses return the last value seen on that chip's bus until a
// model-dependent time-to-live expires and the value decays to 0x00.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   phi2_tick  single-cycle strobe; all bus actions happen only on it
//   addr       register address (5 bits)
//   data_i     write data
//   we, oe     write / read enables, sampled on phi2_tick
//   res        SID chip reset, sampled on phi2_tick
//   cs_n       active-low chip select per SID
//   model      per-SID model, 0 = MOS6581, 1 = MOS8580
//   misc       per-SID read-only bytes, SID k in [32k+31:32k], POTX on top
//   regs       per-SID write-only registers, byte 0 of SID k on top of the
//              200-bit slice
//   data_o     read data
//   data_oe    read data valid / bus drive enable
module sid_multi_regfile #(
  parameter int N_SID    = 2,
  parameter int TTL_6581 = 7424,
  parameter int TTL_8580 = 663552,
  parameter int TTL_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  phi2_tick,
  input  logic [4:0]            addr,
  input  logic [7:0]            data_i,
  input  logic                  we,
  input  logic                  oe,
  input  logic                  res,
  input  logic [N_SID-1:0]      cs_n,
  input  logic [N_SID-1:0]      model,
  input  logic [N_SID*32-1:0]   misc,
  output logic [N_SID*200-1:0]  regs,
  output logic [7:0]            data_o,
  output logic                  data_oe
);

  localparam logic [TTL_W-1:0] RELOAD_6581 = TTL_W'(TTL_6581);
  localparam logic [TTL_W-1:0] RELOAD_8580 = TTL_W'(TTL_8580);

  logic [N_SID*200-1:0] regs_q, regs_d;
  logic [7:0]           busVal_q [N_SID];
  logic [7:0]           busVal_d [N_SID];
  logic [TTL_W-1:0]     ttl_q [N_SID];
  logic [TTL_W-1:0]     ttl_d [N_SID];
  logic [7:0]           dataOut_q, dataOut_d;
  logic                 dataOe_q, dataOe_d;

  logic                 isWrite;
  logic                 isRead;
  logic                 addrIsMisc;
  logic [1:0]           miscSel;
  logic [N_SID-1:0]     readSel;
  logic                 srcFound;
  logic [7:0]           miscByte;

  assign isWrite    = phi2_tick && !res && we;
  assign isRead     = phi2_tick && !res && oe && !we;
  assign addrIsMisc = (addr >= 5'h19) && (addr <= 5'h1C);
  // 0x19..0x1C have low bits 01,10,11,00; subtracting one maps them to 0..3
  assign miscSel    = addr[1:0] - 2'd1;

  // A read is served by the lowest-index selected chip only.
  always_comb begin
    readSel  = '0;
    srcFound = 1'b0;
    for (int k = 0; k < N_SID; k++) begin
      if (!cs_n[k] && !srcFound) begin
        readSel[k] = 1'b1;
        srcFound   = 1'b1;
      end
    end
  end

  // Next-state: chip reset wins, then decay, then the access, whose TTL
  // reload overrides the decrement. A read restores the pre-decay bus
  // value so an expiring TTL on the read tick does not lose it.
  always_comb begin
    regs_d    = regs_q;
    busVal_d  = busVal_q;
    ttl_d     = ttl_q;
    dataOut_d = dataOut_q;
    dataOe_d  = dataOe_q;
    miscByte  = '0;
    if (phi2_tick) begin
      if (res) begin
        regs_d    = '0;
        dataOut_d = '0;
        dataOe_d  = 1'b0;
        for (int k = 0; k < N_SID; k++) begin
          busVal_d[k] = '0;
          ttl_d[k]    = '0;
        end
      end else begin
        dataOe_d = isRead && (|readSel);
        for (int k = 0; k < N_SID; k++) begin
          if (ttl_q[k] != '0) begin
            ttl_d[k] = ttl_q[k] - TTL_W'(1);
            if (ttl_q[k] == TTL_W'(1)) begin
              busVal_d[k] = '0;
            end
          end
          if (isWrite && !cs_n[k]) begin
            if (addr <= 5'h18) begin
              regs_d[k*200 + (24 - int'(addr))*8 +: 8] = data_i;
            end
            busVal_d[k] = data_i;
            ttl_d[k]    = model[k] ? RELOAD_8580 : RELOAD_6581;
          end
          if (isRead && readSel[k]) begin
            if (addrIsMisc) begin
              miscByte    = misc[k*32 + (3 - int'(miscSel))*8 +: 8];
              dataOut_d   = miscByte;
              busVal_d[k] = miscByte;
            end else begin
              dataOut_d   = busVal_q[k];
              busVal_d[k] = busVal_q[k];
            end
            ttl_d[k] = model[k] ? RELOAD_8580 : RELOAD_6581;
          end
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '0;
      dataOut_q <= '0;
      dataOe_q  <= 1'b0;
      for (int k = 0; k < N_SID; k++) begin
        busVal_q[k] <= '0;
        ttl_q[k]    <= '0;
      end
    end else begin
      regs_q    <= regs_d;
      dataOut_q <= dataOut_d;
      dataOe_q  <= dataOe_d;
      for (int k = 0; k < N_SID; k++) begin
        busVal_q[k] <= busVal_d[k];
        ttl_q[k]    <= ttl_d[k];
      end
    end
  end

  assign regs    = regs_q;
  assign data_o  = dataOut_q;
  assign data_oe = dataOe_q;

endmodule

// File: tb/tb_sid_multi_regfile.sv
// tb_sid_multi_regfile
// Directed bench for sid_multi_regfile with two SIDs and default retention
// times. Expected values are hand-computed constants.
module tb_sid_multi_regfile;

  localparam int N = 2;

  logic           clk;
  logic           rst;
  logic           phi2_tick;
  logic [4:0]     addr;
  logic [7:0]     data_i;
  logic           we;
  logic           oe;
  logic           res;
  logic [N-1:0]   cs_n;
  logic [N-1:0]   model;
  logic [N*32-1:0]  misc;
  logic [N*200-1:0] regs;
  logic [7:0]     data_o;
  logic           data_oe;

  int checks = 0;
  int errors = 0;

  sid_multi_regfile #(
    .N_SID(N), .TTL_6581(7424), .TTL_8580(663552), .TTL_W(20)
  ) dut (
    .clk(clk), .rst(rst), .phi2_tick(phi2_tick), .addr(addr),
    .data_i(data_i), .we(we), .oe(oe), .res(res), .cs_n(cs_n),
    .model(model), .misc(misc), .regs(regs), .data_o(data_o),
    .data_oe(data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] regByte(input int sid, input int b);
    return regs[sid*200 + (24 - b)*8 +: 8];
  endfunction

  // Compare one observed value against its expected constant.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one phi2 tick with the given bus action; returns at the next
  // falling edge, one clk after the tick was sampled.
  task automatic applyStimulus(input logic w, input logic r, input logic rs,
                               input logic [4:0] a, input logic [7:0] d,
                               input logic [N-1:0] cs);
    @(negedge clk);
    we = w; oe = r; res = rs; addr = a; data_i = d; cs_n = cs;
    phi2_tick = 1'b1;
    @(negedge clk);
    phi2_tick = 1'b0;
    we = 1'b0; oe = 1'b0; res = 1'b0; cs_n = '1;
  endtask

  // n consecutive ticks with no chip selected.
  task automatic idleTicks(input int n);
    @(negedge clk);
    we = 1'b0; oe = 1'b0; res = 1'b0; cs_n = '1;
    phi2_tick = 1'b1;
    repeat (n) @(negedge clk);
    phi2_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; phi2_tick = 1'b0; addr = '0; data_i = '0;
    we = 1'b0; oe = 1'b0; res = 1'b0; cs_n = '1; model = '0;
    misc = {32'h11223344, 32'hA1B2C3D4};
    repeat (3) @(negedge clk);
    checkOutput("reset_data_oe", {31'b0, data_oe}, 32'h0);
    checkOutput("reset_data_o", {24'b0, data_o}, 32'h0);
    checkOutput("reset_regs", {31'b0, |regs}, 32'h0);
    rst = 1'b0;

    // write enable without a tick must not change anything
    @(negedge clk);
    we = 1'b1; addr = 5'h05; data_i = 8'h33; cs_n = 2'b10;
    @(negedge clk);
    we = 1'b0; cs_n = '1;
    checkOutput("no_tick_write", {24'b0, regByte(0, 5)}, 32'h0);

    // single-chip write, then read of a write-only address
    applyStimulus(1'b1, 1'b0, 1'b0, 5'h04, 8'h5A, 2'b10);
    checkOutput("wr_sid0_b4", {24'b0, regByte(0, 4)}, 32'h5A);
    checkOutput("wr_sid1_b4", {24'b0, regByte(1, 4)}, 32'h00);
    checkOutput("wr_data_oe", {31'b0, data_oe}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 8'h00, 2'b10);
    checkOutput("rd_sid0_data", {24'b0, data_o}, 32'h5A);
    checkOutput("rd_sid0_oe", {31'b0, data_oe}, 32'h1);
    @(negedge clk);
    checkOutput("rd_oe_hold", {31'b0, data_oe}, 32'h1);

    // read-only register of SID1, then retained bus value
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h1B, 8'h00, 2'b01);
    checkOutput("rd_sid1_osc3", {24'b0, data_o}, 32'h33);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h10, 8'h00, 2'b01);
    checkOutput("rd_sid1_retain", {24'b0, data_o}, 32'h33);

    // 6581 decay: one tick short of expiry keeps the value
    model = 2'b00;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'h00, 8'hAA, 2'b10);
    idleTicks(7423);
    checkOutput("idle_oe_low", {31'b0, data_oe}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 8'h00, 2'b10);
    checkOutput("decay_7423", {24'b0, data_o}, 32'hAA);
    // exact expiry clears it
    applyStimulus(1'b1, 1'b0, 1'b0, 5'h00, 8'hAA, 2'b10);
    idleTicks(7424);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 8'h00, 2'b10);
    checkOutput("decay_7424", {24'b0, data_o}, 32'h00);
    checkOutput("decay_7424_oe", {31'b0, data_oe}, 32'h1);
    // 8580 retains much longer
    model = 2'b01;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'h00, 8'hAA, 2'b10);
    idleTicks(7424);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 8'h00, 2'b10);
    checkOutput("decay_8580", {24'b0, data_o}, 32'hAA);

    // broadcast write and lowest-index read source
    model = 2'b00;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'h18, 8'h7F, 2'b00);
    checkOutput("bcast_sid0", {24'b0, regByte(0, 24)}, 32'h7F);
    checkOutput("bcast_sid1", {24'b0, regByte(1, 24)}, 32'h7F);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h1C, 8'h00, 2'b00);
    checkOutput("bcast_rd_env3", {24'b0, data_o}, 32'hD4);
    // SID1 was not reloaded by that read, so it expires one tick earlier
    idleTicks(7423);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h00, 8'h00, 2'b01);
    checkOutput("sid1_not_reloaded", {24'b0, data_o}, 32'h00);

    // chip reset overrides a write on the same tick
    applyStimulus(1'b1, 1'b0, 1'b1, 5'h01, 8'hFF, 2'b00);
    checkOutput("res_regs", {31'b0, |regs}, 32'h0);
    checkOutput("res_data_oe", {31'b0, data_oe}, 32'h0);
    checkOutput("res_data_o", {24'b0, data_o}, 32'h0);

    // asynchronous reset right after a read
    applyStimulus(1'b1, 1'b0, 1'b0, 5'h03, 8'h42, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h03, 8'h00, 2'b10);
    checkOutput("pre_rst_read", {24'b0, data_o}, 32'h42);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_oe", {31'b0, data_oe}, 32'h0);
    checkOutput("async_rst_regs", {31'b0, |regs}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // we and oe together act as a write to an unmapped register
    applyStimulus(1'b1, 1'b1, 1'b0, 5'h19, 8'h99, 2'b10);
    checkOutput("weoe_regs", {31'b0, |regs}, 32'h0);
    checkOutput("weoe_data_oe", {31'b0, data_oe}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'h02, 8'h00, 2'b10);
    checkOutput("weoe_busval", {24'b0, data_o}, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_multi_regfile.md
Name: sid_multi_regfile

Overview:
- Parametrised register file and bus interface for N SID instances sharing one 6502-style bus.
- Captures per-SID write-only register bytes 0x00–0x18 and returns the read-only registers 0x19–0x1C.
- Emulates per-SID data-bus value retention with model-dependent decay: reads of write-only or unmapped registers return the last bus value until it decays to 0x00.
- Sits between the bus synchroniser and the per-SID cores. It generalises the single-SID register interface to N chips, with broadcast writes and chip-reset handling.

Parameters:
- N_SID, 2, number of SID instances (1..4).
- TTL_6581, 7424, bus-value retention in phi2 ticks for MOS6581.
- TTL_8580, 663552, bus-value retention in phi2 ticks for MOS8580.
- TTL_W, 20, retention counter width; must hold max(TTL_6581, TTL_8580).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- phi2_tick  in  1  single-cycle strobe marking the phi2 bus sample point. All bus actions occur only on this cycle.
- addr  in  5  register address.
- data_i  in  8  write data.
- we  in  1  write enable, sampled on phi2_tick.
- oe  in  1  read enable, sampled on phi2_tick.
- res  in  1  SID chip reset (bus RES), sampled on phi2_tick.
- cs_n  in  N_SID  active-low chip select per SID.
- model  in  N_SID  per-SID model: 0=MOS6581, 1=MOS8580.
- misc  in  N_SID*32  per-SID read-only bytes POTX, POTY, OSC3, ENV3. SID k occupies bits [32k+31:32k]; POTX is the MSB byte.
- regs  out  N_SID*200  per-SID write-only registers 0x00..0x18. Byte 0 of SID k is the MSB byte of the 200-bit slice.
- data_o  out  8  read data.
- data_oe  out  1  read data valid / bus drive enable.

Behaviour:
- Reset (rst high, async): all regs bytes = 0x00, all bus values = 0x00, all TTL counters = 0, data_o = 0x00, data_oe = 0.
- No state changes on cycles without phi2_tick.
- Precedence on a phi2_tick:
  1. res high: same clearing as rst; we and oe are ignored on that tick; data_oe = 0.
  2. Otherwise, decay: each SID with TTL ≠ 0 decrements TTL. On transition to 0, bus value := 0x00.
  3. Access: a write or read to SID k reloads TTL[k] to TTL_6581 or TTL_8580 per model[k]. The reload overrides the decrement on the same tick.
- Write (we=1 and cs_n[k]=0):
  - addr ≤ 0x18: regs byte addr of SID k := data_i.
  - addr ≥ 0x19: no register write.
  - In both cases bus value[k] := data_i.
  - Writes are broadcast to every selected SID.
- Read (oe=1, we=0, any cs_n low): source is the lowest-index selected SID s.
  - addr 0x19..0x1C: data_o := misc byte (addr−0x19) of s, and bus value[s] := that byte.
  - All other addresses: data_o := bus value[s], unchanged.
  - Only TTL[s] is reloaded.
- we=1 and oe=1 together: treated as a write; no read.
- data_oe: registered; goes to 1 the cycle after a read tick and stays there until the next phi2_tick. On any tick without a read it goes to 0. data_o holds its value when data_oe=0.
- Read latency: 1 clk after phi2_tick.
- regs changes become visible 1 clk after the write tick.
- TTL reaching 0 on the same tick as a read of a write-only register: the read returns the pre-decay value, and TTL is reloaded.
- model changing mid-count: affects only the next reload.
- rst mid-read: data_oe drops immediately.
- All selects high: no action apart from decay.

Test Plan:
- Reset, then write 0x5A to addr 0x04 of SID0 with cs_n=2'b10 -> regs SID0 byte 4 = 0x5A, SID1 unchanged 0x00; read addr 0x00 of SID0 -> data_o=0x5A, data_oe=1 one clk after tick.
- misc SID1 = 0x11223344; read addr 0x1B of SID1 -> data_o=0x33; then read addr 0x10 of SID1 -> 0x33 (bus value retained).
- model=MOS6581, write 0xAA to SID0, apply 7423 idle ticks, read addr 0x00 -> 0xAA. Repeat with 7424 idle ticks -> 0x00. With model=8580, 7424 idle ticks -> 0xAA.
- cs_n=2'b00, write 0x7F to addr 0x18 -> both SIDs byte 0x18 = 0x7F; read addr 0x1C -> SID0 ENV3 returned, and only SID0 TTL reloaded.
- res=1 on a tick with we=1, addr 0x01, data 0xFF -> all regs 0x00, no write, data_oe=0; assert rst asynchronously mid-cycle after a read -> data_oe=0 immediately.
- we=oe=1 with addr 0x19 and data 0x99 -> no register write, data_oe=0, bus value=0x99; a subsequent read of addr 0x02 returns 0x99.
